instr_load_sched: RTL

- Owns the instruction BRAM write side and gates every fetch shift issued to the instruction memory controller.
- Sequences program load from a host byte stream, then releases the core to fetch.
- Bounds-checks each fetch window and jump against the loaded program length.
- Arbitrates host reload against running fetch by halting the core at a cycle boundary.

---
 rtl/instr_load_sched.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_load_sched.sv
// instr_load_sched: owns the instruction BRAM write port, sequences program
// load from a host byte stream, releases the core, and bounds-checks every
// fetch shift / jump against the loaded program length.
// Optional feature macro: LOAD_CSUM_EN (modulo-256 byte checksum on load).
module instr_load_sched #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic [7:0]            load_csum,
  input  logic                  load_vld,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_rdy,
  output logic                  load_done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_hlt,
  output logic                  core_start,
  input  logic                  fetch_req,
  input  logic [7:0]            fetch_shift_minusone,
  input  logic                  fetch_jump_en,
  input  logic [ADDR_WIDTH-1:0] fetch_jump_addr,
  input  logic [ADDR_WIDTH-1:0] fetch_ptr,
  output logic                  mem_shift_vld,
  output logic [7:0]            mem_shift_minusone,
  output logic                  mem_jump_en,
  output logic [ADDR_WIDTH-1:0] mem_jump_addr,
  output logic                  fault,
  output logic [1:0]            fault_code,
  output logic [ADDR_WIDTH:0]   prog_len
);

  localparam int LW = ADDR_WIDTH + 1;
  // End-of-window width: wide enough that base + shift + 1 never wraps.
  localparam int EW = ((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8) + 2;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  localparam logic [1:0] FC_OVERRUN = 2'd1;
  localparam logic [1:0] FC_JUMP    = 2'd2;
  localparam logic [1:0] FC_LOAD    = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FAULT} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   wcnt_q, wcnt_d;
  logic [LW-1:0]   plen_q, plen_d;
  logic            fault_q, fault_d;
  logic [1:0]      code_q, code_d;
  logic            start_q, start_d;

  logic            len_nz, len_bad, reload, last_byte, csum_ok;
  logic            jump_bad, over_bad;
  logic [ADDR_WIDTH-1:0] base;
  logic [EW-1:0]   fetch_end;

`ifdef LOAD_CSUM_EN
  logic [7:0]      csum_q, csum_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      sum_next;

  // Running sum including the byte being accepted this cycle.
  assign sum_next = sum_q + 8'(load_data);
  assign csum_ok  = (sum_next == csum_q);
`else
  logic [7:0]      unused_csum;

  assign unused_csum = load_csum;
  assign csum_ok     = 1'b1;
`endif

  // Length qualification shared by IDLE, RUN (reload) and FAULT.
  assign len_nz  = (load_len != '0);
  assign len_bad = (load_len > DEPTH_L);

  // A non-empty load_start in RUN preempts the core this very cycle.
  assign reload  = (state_q == S_RUN) && load_start && len_nz;

  // Fetch window bounds check, purely combinational.
  assign base      = fetch_jump_en ? fetch_jump_addr : fetch_ptr;
  assign fetch_end = EW'(base) + EW'(fetch_shift_minusone) + EW'(1);
  assign jump_bad  = fetch_jump_en && (LW'(fetch_jump_addr) >= plen_q);
  assign over_bad  = fetch_end > EW'(plen_q);

  assign last_byte = (state_q == S_LOAD) && load_vld && (wcnt_q == len_q - LW'(1));

  // Next-state and register updates for the load/run/fault sequencer.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    plen_d  = plen_q;
    fault_d = fault_q;
    code_d  = code_q;
    start_d = 1'b0;
`ifdef LOAD_CSUM_EN
    csum_d  = csum_q;
    sum_d   = sum_q;
`endif
    if ((state_q != S_LOAD) && load_start && len_nz) begin
      // Program (re)load request: wins over any concurrent fetch fault.
      if (len_bad) begin
        state_d = S_FAULT;
        fault_d = 1'b1;
        code_d  = FC_LOAD;
      end else begin
        state_d = S_LOAD;
        len_d   = load_len;
        wcnt_d  = '0;
        fault_d = 1'b0;
        code_d  = 2'd0;
`ifdef LOAD_CSUM_EN
        csum_d  = load_csum;
        sum_d   = '0;
`endif
      end
    end else begin
      case (state_q)
        S_LOAD: begin
          if (load_vld) begin
            wcnt_d = wcnt_q + LW'(1);
`ifdef LOAD_CSUM_EN
            sum_d  = sum_next;
`endif
            if (last_byte) begin
              plen_d = len_q;
              if (csum_ok) begin
                state_d = S_RUN;
                start_d = 1'b1;
              end else begin
                state_d = S_FAULT;
                fault_d = 1'b1;
                code_d  = FC_LOAD;
              end
            end
          end
        end
        S_RUN: begin
          if (fetch_req && jump_bad) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            code_d  = FC_JUMP;
          end else if (fetch_req && over_bad) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            code_d  = FC_OVERRUN;
          end
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous reset; BRAM contents are untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      plen_q  <= '0;
      fault_q <= 1'b0;
      code_q  <= 2'd0;
      start_q <= 1'b0;
`ifdef LOAD_CSUM_EN
      csum_q  <= '0;
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      plen_q  <= plen_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      start_q <= start_d;
`ifdef LOAD_CSUM_EN
      csum_q  <= csum_d;
      sum_q   <= sum_d;
`endif
    end
  end

  // Host write path: bytes land in BRAM in the cycle they are accepted.
  assign load_rdy  = (state_q == S_LOAD);
  assign mem_we    = load_rdy && load_vld;
  assign mem_waddr = wcnt_q[ADDR_WIDTH-1:0];
  assign mem_wdata = load_data;

  // Core control and gated fetch path.
  assign core_hlt           = (state_q != S_RUN) || reload;
  assign mem_shift_vld      = (state_q == S_RUN) && !reload && fetch_req && !jump_bad && !over_bad;
  assign mem_shift_minusone = fetch_shift_minusone;
  assign mem_jump_en        = fetch_jump_en;
  assign mem_jump_addr      = fetch_jump_addr;

  assign load_done  = start_q;
  assign core_start = start_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign prog_len   = plen_q;

endmodule
